// File: rtl/lit_mem_reader.sv
// Sequential literal-memory scanner: one literal per cycle, matching entries
// streamed over a valid/ready port (first-unassigned, level dump, model dump).
module lit_mem_reader #(
    parameter int WIDTH        = 9,
    parameter int MAX_LITERALS = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [1:0]                    mode,
    input  logic [WIDTH-1:0]              target_level,
    input  logic [MAX_LITERALS-1:0]       literal_assigned_in,
    input  logic [MAX_LITERALS-1:0]       literal_bool_val_in,
    input  logic [MAX_LITERALS*WIDTH-1:0] literal_updated_level_in_packed,
    input  logic                          out_ready,
    output logic                          out_valid,
    output logic [WIDTH-2:0]              out_lit,
    output logic                          out_bool_val,
    output logic [WIDTH-1:0]              out_level,
    output logic                          busy,
    output logic                          done,
    output logic [WIDTH-1:0]              count
);

    localparam logic [1:0] M_FIRST = 2'd0;
    localparam logic [1:0] M_LEVEL = 2'd1;
    localparam logic [1:0] M_MODEL = 2'd2;
    localparam logic [1:0] M_RSVD  = 2'd3;
    localparam logic [WIDTH-2:0] LAST_IDX = (WIDTH-1)'(MAX_LITERALS-1);

    typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-2:0] idx;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] level_r;
    logic [WIDTH-1:0] lvl_mem [MAX_LITERALS];
    logic             cur_asg, match, last;

    for (genvar i = 0; i < MAX_LITERALS; i++) begin : g_unpack
        assign lvl_mem[i] = literal_updated_level_in_packed[(i+1)*WIDTH-1 -: WIDTH];
    end

    assign cur_asg = literal_assigned_in[idx];
    assign last    = (idx == LAST_IDX);

    always_comb begin
        match = 1'b0;
        case (mode_r)
            M_FIRST: match = !cur_asg;
            M_LEVEL: match = cur_asg && (lvl_mem[idx] == level_r);
            M_MODEL: match = cur_asg;
            default: match = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = SCAN;
            SCAN: begin
                if (mode_r == M_RSVD)  state_nxt = DONE;
                else if (match)        state_nxt = EMIT;
                else if (last)         state_nxt = DONE;
            end
            EMIT: if (out_ready) state_nxt = (mode_r == M_FIRST || last) ? DONE : SCAN;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);

    // Item registers are loaded only on a match and otherwise hold, so the
    // consumer sees stable data for the whole EMIT stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx          <= '0;
            count        <= '0;
            mode_r       <= '0;
            level_r      <= '0;
            out_valid    <= 1'b0;
            out_lit      <= '0;
            out_bool_val <= 1'b0;
            out_level    <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mode_r  <= mode;
                    level_r <= target_level;
                    idx     <= '0;
                    count   <= '0;
                end
                SCAN: begin
                    if (mode_r != M_RSVD && match) begin
                        out_valid    <= 1'b1;
                        out_lit      <= idx;
                        out_bool_val <= literal_bool_val_in[idx];
                        out_level    <= lvl_mem[idx];
                    end else if (!last) begin
                        idx <= idx + 1'b1;
                    end
                end
                EMIT: if (out_ready) begin
                    count     <= count + 1'b1;
                    out_valid <= 1'b0;
                    if (!(mode_r == M_FIRST || last)) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lit_mem_reader.sv
// Bench for lit_mem_reader: scoreboard of expected items built from the scan
// rules, a per-cycle compare process, and directed timing expectations.
module tb_lit_mem_reader;
    localparam int W = 9;
    localparam int N = 256;

    logic             clk = 1'b0;
    logic             rst, start, out_ready;
    logic [1:0]       mode;
    logic [W-1:0]     target_level;
    logic [N-1:0]     asg, bval;
    logic [W-1:0]     lvl_m [N];
    logic [N*W-1:0]   lvl_p;
    logic             out_valid, out_bool_val, busy, done;
    logic [W-2:0]     out_lit;
    logic [W-1:0]     out_level, count;

    lit_mem_reader #(.WIDTH(W), .MAX_LITERALS(N)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .target_level(target_level),
        .literal_assigned_in(asg), .literal_bool_val_in(bval),
        .literal_updated_level_in_packed(lvl_p), .out_ready(out_ready),
        .out_valid(out_valid), .out_lit(out_lit), .out_bool_val(out_bool_val),
        .out_level(out_level), .busy(busy), .done(done), .count(count)
    );

    always #5 clk = ~clk;

    always_comb begin
        lvl_p = '0;
        for (int i = 0; i < N; i++) lvl_p[i*W +: W] = lvl_m[i];
    end

    typedef struct { int lit; int val; int lvl; } item_t;
    item_t exp_q[$];
    int    exp_total;
    int    n_cmp = 0, n_err = 0;
    bit    chk_en = 0, held = 0;
    int    prev_lit, prev_val, prev_lvl;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: walk the memory in index order applying the mode's rule.
    task automatic build(input int m, input int tl);
        exp_q.delete();
        for (int i = 0; i < N; i++) begin
            bit hit;
            case (m)
                0: hit = !asg[i];
                1: hit = asg[i] && (int'(lvl_m[i]) == tl);
                2: hit = asg[i];
                default: hit = 0;
            endcase
            if (hit) begin
                exp_q.push_back('{i, int'(bval[i]), int'(lvl_m[i])});
                if (m == 0) break;
            end
        end
        exp_total = exp_q.size();
    endtask

    always @(posedge clk) begin
        held <= out_valid && !out_ready;
        if (chk_en && out_valid && out_ready && exp_q.size() > 0) void'(exp_q.pop_front());
    end

    always @(negedge clk) begin
        if (chk_en && !rst) begin
            if (out_valid) begin
                chk("item_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    chk("out_lit", int'(out_lit), exp_q[0].lit);
                    chk("out_bool_val", int'(out_bool_val), exp_q[0].val);
                    chk("out_level", int'(out_level), exp_q[0].lvl);
                end
                chk("busy_in_emit", int'(busy), 1);
                if (held) begin
                    chk("stall_lit", int'(out_lit), prev_lit);
                    chk("stall_val", int'(out_bool_val), prev_val);
                    chk("stall_lvl", int'(out_level), prev_lvl);
                end
                prev_lit = int'(out_lit);
                prev_val = int'(out_bool_val);
                prev_lvl = int'(out_level);
            end
            if (done) begin
                chk("queue_drained", exp_q.size(), 0);
                chk("count_at_done", int'(count), exp_total);
            end
        end
    end

    task automatic clear_mem();
        asg = '0; bval = '0;
        for (int i = 0; i < N; i++) lvl_m[i] = '0;
    endtask

    task automatic setup_level();
        clear_mem();
        asg[2] = 1;  bval[2] = 1;  lvl_m[2] = 9'd3;
        asg[9] = 1;  bval[9] = 0;  lvl_m[9] = 9'd3;
        asg[10] = 1; bval[10] = 1; lvl_m[10] = 9'd2;
    endtask

    // Cycle 1 is the cycle after the edge that samples start.
    task automatic run(input int m, input int tl, input int stall, input bit idle_rdy,
                       input int inj, output int fv, output int dc, output int fl);
        int cyc, vhold;
        bit got;
        build(m, tl);
        fv = -1; dc = -1; fl = -1; vhold = 0; got = 0;
        @(negedge clk);
        start = 1; mode = 2'(m); target_level = W'(tl); out_ready = idle_rdy; chk_en = 1;
        cyc = 1;
        @(negedge clk);
        while (cyc < 1500 && !got) begin
            if (cyc == inj) begin start = 1; mode = 2'(m) ^ 2'b01; end
            else begin start = 0; mode = 2'(m); end
            if (out_valid) begin
                if (fv < 0) begin fv = cyc; fl = int'(out_lit); end
                out_ready = (vhold >= stall);
                if (out_ready) vhold = 0; else vhold++;
            end else out_ready = idle_rdy;
            if (done) begin got = 1; dc = cyc; end
            else begin cyc++; @(negedge clk); end
        end
        start = 0;
        chk("done_within_bound", int'(got), 1);
        @(negedge clk);
        chk("idle_after_done", int'({busy, done, out_valid}), 0);
        chk_en = 0; out_ready = 0;
    endtask

    int fv, dc, fl;

    initial begin
        rst = 1; start = 0; out_ready = 0; mode = 0; target_level = 0;
        clear_mem();
        repeat (3) @(negedge clk);
        chk("rst_state", int'({out_valid, out_bool_val, busy, done}), 0);
        chk("rst_lit_lvl_cnt", int'(out_lit) + int'(out_level) + int'(count), 0);
        rst = 0;

        // first unassigned: 0..4 assigned -> literal 5
        clear_mem();
        for (int i = 0; i < 5; i++) asg[i] = 1;
        run(0, 0, 0, 1, -1, fv, dc, fl);
        chk("t1_valid_cycle", fv, 7);
        chk("t1_lit", fl, 5);
        chk("t1_done_cycle", dc, 8);
        chk("t1_count", int'(count), 1);

        // first unassigned with everything assigned
        asg = '1;
        run(0, 0, 0, 1, -1, fv, dc, fl);
        chk("t2_no_valid", fv, -1);
        chk("t2_done_cycle", dc, 257);
        chk("t2_count", int'(count), 0);

        // level dump at level 3
        setup_level();
        run(1, 3, 0, 0, -1, fv, dc, fl);
        chk("t3_model_total", exp_total, 2);
        chk("t3_valid_cycle", fv, 4);
        chk("t3_first_lit", fl, 2);
        chk("t3_done_cycle", dc, 259);
        chk("t3_count", int'(count), 2);

        // model dump, only the last literal, 4-cycle stall
        clear_mem();
        asg[255] = 1; bval[255] = 1; lvl_m[255] = 9'd7;
        run(2, 0, 4, 0, -1, fv, dc, fl);
        chk("t4_valid_cycle", fv, 257);
        chk("t4_lit", fl, 255);
        chk("t4_done_cycle", dc, 262);
        chk("t4_count", int'(count), 1);

        // reset while an item is pending
        setup_level();
        @(negedge clk);
        start = 1; mode = 2'd1; target_level = 9'd3; out_ready = 0;
        @(negedge clk);
        start = 0;
        for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
        chk("t5_reached_emit", int'(out_valid), 1);
        rst = 1;
        @(negedge clk);
        chk("t5_valid_cleared", int'(out_valid), 0);
        chk("t5_busy_cleared", int'(busy), 0);
        chk("t5_count_cleared", int'(count), 0);
        chk("t5_no_done", int'(done), 0);
        chk("t5_lit_cleared", int'(out_lit), 0);
        rst = 0;
        run(1, 3, 0, 0, -1, fv, dc, fl);
        chk("t5_restart_valid", fv, 4);
        chk("t5_restart_lit", fl, 2);
        chk("t5_restart_count", int'(count), 2);

        // start while busy (during EMIT) with another mode is ignored
        run(1, 3, 0, 0, 4, fv, dc, fl);
        chk("t6_valid_cycle", fv, 4);
        chk("t6_done_cycle", dc, 259);
        chk("t6_count", int'(count), 2);

        // reserved mode finishes immediately
        run(3, 0, 0, 1, -1, fv, dc, fl);
        chk("t7_no_valid", fv, -1);
        chk("t7_done_cycle", dc, 2);
        chk("t7_count", int'(count), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lit_mem_reader.md
# lit_mem_reader

Sequential read-side companion to the literal-memory update mux. On a `start` pulse it scans the literal memory one literal per cycle and streams matching entries over a valid/ready port. Three scan modes are supported: the first unassigned literal (decision candidate), all literals assigned at a given level (backtrack trail), or all assigned literals (final model dump). It sits between literal memory and the decision, backtrack and result-output logic.

## Interface
- `WIDTH`, 9, level width; literal index width is `WIDTH-1`
- `MAX_LITERALS`, 256, number of literals in memory
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin scan; sampled only in IDLE
- `mode`  in  2  0 = FIRST_UNASSIGNED, 1 = LEVEL_DUMP, 2 = MODEL_DUMP, 3 = reserved
- `target_level`  in  WIDTH  level matched in LEVEL_DUMP
- `literal_assigned_in`  in  MAX_LITERALS  assigned flags from literal memory
- `literal_bool_val_in`  in  MAX_LITERALS  boolean values from literal memory
- `literal_updated_level_in_packed`  in  MAX_LITERALS*WIDTH  levels; literal i at `[(i+1)*WIDTH-1 -: WIDTH]`
- `out_ready`  in  1  consumer accepts the current item
- `out_valid`  out  1  item valid
- `out_lit`  out  WIDTH-1  literal index
- `out_bool_val`  out  1  literal value
- `out_level`  out  WIDTH  literal updated level
- `busy`  out  1  high in any state other than IDLE
- `done`  out  1  one-cycle pulse at scan end
- `count`  out  WIDTH  items handed off in the last or current scan

## Operation
- Clock and reset are fixed: one clock `clk`; `rst` is synchronous and active-high.
- FSM states: IDLE, SCAN, EMIT, DONE. A register `idx` (WIDTH-1 bits) holds the literal under test.
- IDLE, on `start`:
  - latch `mode` and `target_level`
  - set `idx=0` and `count=0`
  - go to SCAN
  - `start` in any other state is ignored.
- SCAN tests literal `idx` each cycle. Match conditions:
  - FIRST_UNASSIGNED: `!assigned[idx]`
  - LEVEL_DUMP: `assigned[idx] && level[idx]==target_level`
  - MODEL_DUMP: `assigned[idx]`
  - reserved: never matches; this mode goes straight to DONE from the first SCAN cycle.
- SCAN outcome:
  - match: register `out_lit=idx`, `out_bool_val`, `out_level`; set `out_valid=1`; go to EMIT.
  - no match and `idx==MAX_LITERALS-1`: go to DONE.
  - no match otherwise: `idx` increments.
- EMIT holds all outputs stable until `out_valid && out_ready`. On handshake:
  - `count` increments and `out_valid` clears.
  - In FIRST_UNASSIGNED, or when `idx==MAX_LITERALS-1`, go to DONE.
  - Otherwise increment `idx` and return to SCAN.
- DONE: `done=1` for exactly one cycle, then IDLE. `count` holds until the next `start`.
- Memory inputs must stay stable while `busy`; the reader samples them live with no snapshot.
- `count` saturates naturally: at most MAX_LITERALS items, which fits in WIDTH bits when `MAX_LITERALS < 2^WIDTH`.

## Timing
- Reset values:
  - state IDLE, `idx=0`, `count=0`
  - `out_valid=0`, `out_lit=0`, `out_bool_val=0`, `out_level=0`
  - `busy=0`, `done=0`
- `start` accepted at edge 0 puts SCAN on literal 0 in cycle 1.
- A first match at index k (no earlier stalls) gives `out_valid` high from cycle k+2.
- Each EMIT costs one cycle plus the back-pressure cycles before `out_ready`. The next SCAN resumes at idx+1 the cycle after the handshake.
- A scan with no match asserts `done` in cycle MAX_LITERALS+1, e.g. 257.
- `done` follows the final handshake by one cycle, or the final SCAN by one cycle.
- `out_ready` held high while `out_valid` is low has no effect.
- `rst` mid-scan or mid-EMIT returns to IDLE next edge with all outputs at reset values and no `done` pulse. A pending item is dropped.
- `rst` and `start` in the same cycle: reset wins.

## Test plan
- FIRST_UNASSIGNED, literals 0–4 assigned, literal 5 unassigned, `out_ready=1` -> single item `out_lit=5`, `out_valid` first high in cycle 7; `done` pulse next cycle; `count=1`.
- FIRST_UNASSIGNED, all 256 assigned -> no `out_valid`; `done` in cycle 257; `count=0`.
- LEVEL_DUMP, `target_level=3`, literals 2 (val 1, lvl 3), 9 (val 0, lvl 3), 10 (val 1, lvl 2) assigned -> items (2,1,3) then (9,0,3) in order; literal 10 skipped; `count=2`.
- MODEL_DUMP, literal 255 assigned val 1 lvl 7, `out_ready` low for 4 cycles after `out_valid` rises -> outputs stable through the stall; handshake on cycle 5 of valid; `done` next cycle; `idx` does not wrap.
- `rst` asserted while in EMIT for LEVEL_DUMP -> next cycle `out_valid=0`, `busy=0`, `count=0`, no `done`; a new `start` then scans from literal 0.
- `start` pulsed while `busy` with a different `mode` -> ignored; the original scan's items and `count` are unchanged.
